// File: rtl/arch_state_checker.sv
`default_nettype none
// arch_state_checker -- run-then-compare end-of-run architectural state verifier (rev 1.0)
// `define ARCH_CHK_MISMATCH_LOG_EN to add the per-mismatch log outputs (mm_*).
module arch_state_checker #(
  parameter int DWIDTH    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_DEPTH = 16,
  parameter int CWIDTH    = 16,
  parameter int EWIDTH    = 8,
  localparam int AMAX     = (NUM_REGS > MEM_DEPTH) ? NUM_REGS : MEM_DEPTH,
  localparam int AWIDTH   = (AMAX > 1) ? $clog2(AMAX) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CWIDTH-1:0] cycle_limit,
  input  logic              halt,
  output logic              run_en,
  output logic [CWIDTH-1:0] cycles_run,
  output logic              chk_sel,
  output logic [AWIDTH-1:0] chk_addr,
  input  logic [DWIDTH-1:0] dut_rdata,
  input  logic [DWIDTH-1:0] gold_rdata,
  output logic              finish,
  output logic              pass,
  output logic [EWIDTH-1:0] err_count,
  output logic              first_err_sel,
  output logic [AWIDTH-1:0] first_err_addr
`ifdef ARCH_CHK_MISMATCH_LOG_EN
  ,
  output logic              mm_valid,
  output logic              mm_sel,
  output logic [AWIDTH-1:0] mm_addr,
  output logic [DWIDTH-1:0] mm_dut,
  output logic [DWIDTH-1:0] mm_gold
`endif
);

  localparam logic [AWIDTH-1:0] REG_LAST = AWIDTH'(NUM_REGS - 1);
  localparam logic [AWIDTH-1:0] MEM_LAST = AWIDTH'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_CHECK = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [CWIDTH-1:0] limit;
  logic [CWIDTH-1:0] cycles_run_inc;
  logic              idx_sel;
  logic [AWIDTH-1:0] idx;
  logic              chk_valid;
  logic              d_valid;
  logic              d_sel;
  logic [AWIDTH-1:0] d_addr;
  logic              start_ok;
  logic              run_done;
  logic              idx_done;
  logic              d_last;
  logic              mismatch;

  assign cycles_run_inc = cycles_run + CWIDTH'(1);
  assign start_ok       = start && ((state == S_IDLE) || (state == S_DONE));
  assign run_done       = (cycles_run_inc == limit) || halt;
  assign idx_done       = idx_sel && (idx == MEM_LAST);
  assign d_last         = d_sel && (d_addr == MEM_LAST);
  assign mismatch       = d_valid && (dut_rdata != gold_rdata);

  assign run_en = (state == S_RUN);
  assign finish = (state == S_DONE);
  assign pass   = (state == S_DONE) && (err_count == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start)              next_state = S_RUN;
      S_RUN:   if (run_done)           next_state = S_CHECK;
      S_CHECK: if (idx_done)           next_state = S_DRAIN;
      S_DRAIN: if (d_valid && d_last)  next_state = S_DONE;
      S_DONE:  if (start)              next_state = S_RUN;
      default:                         next_state = S_IDLE;
    endcase
  end

  // idx/idx_sel walk the check order; chk_* is their registered copy seen by
  // the read ports, and d_* lines up with the returning synchronous read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      limit          <= '0;
      cycles_run     <= '0;
      idx_sel        <= 1'b0;
      idx            <= '0;
      chk_valid      <= 1'b0;
      chk_sel        <= 1'b0;
      chk_addr       <= '0;
      d_valid        <= 1'b0;
      d_sel          <= 1'b0;
      d_addr         <= '0;
      err_count      <= '0;
      first_err_sel  <= 1'b0;
      first_err_addr <= '0;
    end else begin
      if (state == S_RUN) cycles_run <= cycles_run_inc;

      if (state == S_CHECK) begin
        if (!idx_sel && (idx == REG_LAST)) begin
          idx_sel <= 1'b1;
          idx     <= '0;
        end else begin
          idx <= idx + AWIDTH'(1);
        end
      end else begin
        idx_sel <= 1'b0;
        idx     <= '0;
      end

      chk_valid <= (state == S_CHECK);
      chk_sel   <= (state == S_CHECK) ? idx_sel : 1'b0;
      chk_addr  <= (state == S_CHECK) ? idx : '0;

      d_valid <= chk_valid;
      d_sel   <= chk_sel;
      d_addr  <= chk_addr;

      if (mismatch) begin
        if (err_count != {EWIDTH{1'b1}}) err_count <= err_count + EWIDTH'(1);
        if (err_count == '0) begin
          first_err_sel  <= d_sel;
          first_err_addr <= d_addr;
        end
      end

      if (start_ok) begin
        limit          <= (cycle_limit == '0) ? CWIDTH'(1) : cycle_limit;
        cycles_run     <= '0;
        err_count      <= '0;
        first_err_sel  <= 1'b0;
        first_err_addr <= '0;
      end
    end
  end

`ifdef ARCH_CHK_MISMATCH_LOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_valid <= 1'b0;
      mm_sel   <= 1'b0;
      mm_addr  <= '0;
      mm_dut   <= '0;
      mm_gold  <= '0;
    end else begin
      mm_valid <= mismatch;
      if (mismatch) begin
        mm_sel  <= d_sel;
        mm_addr <= d_addr;
        mm_dut  <= dut_rdata;
        mm_gold <= gold_rdata;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arch_state_checker.sv
`default_nettype none
`timescale 1ns/1ps
// tb_arch_state_checker -- randomized self-checking bench against a list-based reference model.
module tb_arch_state_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int MD = 16;
  localparam int CW = 16;
  localparam int EW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, start, halt;
  logic [CW-1:0] cycle_limit;

  logic          run_en, chk_sel, finish, pass, first_err_sel;
  logic [CW-1:0] cycles_run;
  logic [AW-1:0] chk_addr, first_err_addr;
  logic [DW-1:0] dut_rdata, gold_rdata;
  logic [EW-1:0] err_count;

  logic          s_run_en, s_chk_sel, s_finish, s_pass, s_fes;
  logic [CW-1:0] s_cycles_run;
  logic [AW-1:0] s_chk_addr, s_fea;
  logic [DW-1:0] s_dut, s_gold;
  logic [1:0]    s_err;

`ifdef ARCH_CHK_MISMATCH_LOG_EN
  logic          mm_valid, mm_sel, s_mm_valid, s_mm_sel;
  logic [AW-1:0] mm_addr, s_mm_addr;
  logic [DW-1:0] mm_dut, mm_gold, s_mm_dut, s_mm_gold;
`endif

  logic [DW-1:0] dreg[NR];
  logic [DW-1:0] greg[NR];
  logic [DW-1:0] dmem[MD];
  logic [DW-1:0] gmem[MD];

  int checks = 0;
  int errors = 0;

  arch_state_checker dut (
    .clk(clk), .rst(rst), .start(start), .cycle_limit(cycle_limit), .halt(halt),
    .run_en(run_en), .cycles_run(cycles_run), .chk_sel(chk_sel), .chk_addr(chk_addr),
    .dut_rdata(dut_rdata), .gold_rdata(gold_rdata), .finish(finish), .pass(pass),
    .err_count(err_count), .first_err_sel(first_err_sel), .first_err_addr(first_err_addr)
`ifdef ARCH_CHK_MISMATCH_LOG_EN
    , .mm_valid(mm_valid), .mm_sel(mm_sel), .mm_addr(mm_addr), .mm_dut(mm_dut), .mm_gold(mm_gold)
`endif
  );

  // Narrow error counter copy to observe saturation.
  arch_state_checker #(.EWIDTH(2)) sat (
    .clk(clk), .rst(rst), .start(start), .cycle_limit(cycle_limit), .halt(halt),
    .run_en(s_run_en), .cycles_run(s_cycles_run), .chk_sel(s_chk_sel), .chk_addr(s_chk_addr),
    .dut_rdata(s_dut), .gold_rdata(s_gold), .finish(s_finish), .pass(s_pass),
    .err_count(s_err), .first_err_sel(s_fes), .first_err_addr(s_fea)
`ifdef ARCH_CHK_MISMATCH_LOG_EN
    , .mm_valid(s_mm_valid), .mm_sel(s_mm_sel), .mm_addr(s_mm_addr), .mm_dut(s_mm_dut), .mm_gold(s_mm_gold)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd(input logic golden, input logic sel, input logic [AW-1:0] a);
    if (sel) return golden ? gmem[a[3:0]] : dmem[a[3:0]];
    return golden ? greg[a] : dreg[a];
  endfunction

  always @(posedge clk) begin
    dut_rdata  <= rd(1'b0, chk_sel, chk_addr);
    gold_rdata <= rd(1'b1, chk_sel, chk_addr);
    s_dut      <= rd(1'b0, s_chk_sel, s_chk_addr);
    s_gold     <= rd(1'b1, s_chk_sel, s_chk_addr);
  end

  // Reference: walk registers then memory in check order, counting differences.
  task automatic ref_model(output int cnt, output logic fsel, output int faddr,
                           output logic lsel, output int laddr);
    logic s;
    int   a;
    cnt = 0; fsel = 1'b0; faddr = 0; lsel = 1'b0; laddr = 0;
    for (int p = 0; p < NR + MD; p++) begin
      s = (p >= NR);
      a = s ? p - NR : p;
      if (rd(1'b0, s, AW'(a)) != rd(1'b1, s, AW'(a))) begin
        if (cnt == 0) begin fsel = s; faddr = a; end
        lsel = s; laddr = a;
        cnt++;
      end
    end
  endtask

  task automatic load_base();
    for (int i = 0; i < NR; i++) greg[i] = '0;
    for (int i = 0; i < MD; i++) gmem[i] = '0;
    greg[8] = 32'd273; greg[9] = 32'd1; gmem[0] = 32'd1;
    for (int i = 0; i < NR; i++) dreg[i] = greg[i];
    for (int i = 0; i < MD; i++) dmem[i] = gmem[i];
  endtask

  // h = RUN cycle number (1-based) during which halt is high; 0 = never.
  task automatic run_and_check(input string name, input int lim, input int h);
    int   lmax, leff, ecnt, efa, ela, exp_fin, runs, fin_k, esat, emain;
    logic efs, els;
    int   mm_n;
    logic mm_ls;
    int   mm_la;
    mm_n = 0; mm_ls = 1'b0; mm_la = 0;
    ref_model(ecnt, efs, efa, els, ela);
    lmax    = (lim == 0) ? 1 : lim;
    leff    = (h != 0 && h < lmax) ? h : lmax;
    exp_fin = leff + NR + MD + 2;
    emain   = (ecnt > 255) ? 255 : ecnt;
    esat    = (ecnt > 3) ? 3 : ecnt;

    @(negedge clk); start = 1'b1; cycle_limit = CW'(lim); halt = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cycles_run !== '0 || err_count !== '0 || finish !== 1'b0 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL %s start_clear: cycles_run=%0d err=%0d finish=%b run_en=%b required 0,0,0,1",
               name, cycles_run, err_count, finish, run_en);
    end
    runs  = run_en ? 1 : 0;
    fin_k = 0;
    for (int k = 1; k <= 300 && fin_k == 0; k++) begin
      @(negedge clk); start = 1'b0; halt = (k == h);
      @(posedge clk); #1;
      if (run_en) runs++;
`ifdef ARCH_CHK_MISMATCH_LOG_EN
      if (mm_valid) begin mm_n++; mm_ls = mm_sel; mm_la = int'(mm_addr); end
`endif
      if (finish) fin_k = k;
    end
    @(negedge clk); halt = 1'b0;

    checks++;
    if (fin_k != exp_fin) begin
      errors++;
      $display("FAIL %s finish_latency: got %0d required %0d (0 = timeout)", name, fin_k, exp_fin);
    end
    checks++;
    if (runs != leff) begin
      errors++;
      $display("FAIL %s run_en_cycles: got %0d required %0d", name, runs, leff);
    end
    checks++;
    if (cycles_run !== CW'(leff)) begin
      errors++;
      $display("FAIL %s cycles_run: got %0d required %0d", name, cycles_run, leff);
    end
    checks++;
    if (err_count !== EW'(emain) || pass !== (ecnt == 0)) begin
      errors++;
      $display("FAIL %s err_pass: err=%0d pass=%b required err=%0d pass=%b",
               name, err_count, pass, emain, (ecnt == 0));
    end
    checks++;
    if (first_err_sel !== efs || first_err_addr !== AW'(efa)) begin
      errors++;
      $display("FAIL %s first_err: got sel=%b addr=%0d required sel=%b addr=%0d",
               name, first_err_sel, first_err_addr, efs, efa);
    end
    checks++;
    if (s_err !== 2'(esat) || s_finish !== 1'b1) begin
      errors++;
      $display("FAIL %s sat_err: got %0d finish=%b required %0d finish=1", name, s_err, s_finish, esat);
    end
    checks++;
    if (chk_addr !== '0 || chk_sel !== 1'b0 || finish !== 1'b1) begin
      errors++;
      $display("FAIL %s done_hold: chk_addr=%0d chk_sel=%b finish=%b required 0,0,1",
               name, chk_addr, chk_sel, finish);
    end
`ifdef ARCH_CHK_MISMATCH_LOG_EN
    checks++;
    if (mm_n != ecnt || (ecnt > 0 && (mm_ls !== els || mm_la != ela ||
        mm_dut !== rd(1'b0, els, AW'(ela)) || mm_gold !== rd(1'b1, els, AW'(ela))))) begin
      errors++;
      $display("FAIL %s mm_log: pulses=%0d last sel=%b addr=%0d required pulses=%0d sel=%b addr=%0d",
               name, mm_n, mm_ls, mm_la, ecnt, els, ela);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0; cycle_limit = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({run_en, cycles_run, chk_sel, chk_addr, finish, pass, err_count, first_err_sel, first_err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: run_en=%b cyc=%0d sel=%b addr=%0d fin=%b pass=%b err=%0d fes=%b fea=%0d required all 0",
               run_en, cycles_run, chk_sel, chk_addr, finish, pass, err_count, first_err_sel, first_err_addr);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_match();
    load_base();
    run_and_check("match", 8, 0);
  endtask

  task automatic test_single_mismatch();
    load_base();
    dreg[8] = 32'd272;
    run_and_check("reg8", 8, 0);
  endtask

  task automatic test_two_mismatch();
    load_base();
    dreg[31] = 32'hDEAD_0001;
    dmem[0]  = 32'd7;
    run_and_check("reg31_mem0", 5, 0);
  endtask

  task automatic test_halt();
    load_base();
    run_and_check("halt3", 8, 3);
  endtask

  task automatic test_zero_limit();
    load_base();
    run_and_check("limit0", 0, 0);
  endtask

  task automatic test_saturation();
    load_base();
    dreg[0] = 32'd9; dreg[5] = 32'd1; dreg[20] = 32'hFFFF_FFFF; dmem[3] = 32'd4; dmem[15] = 32'd2;
    run_and_check("saturate", 2, 0);
  endtask

  task automatic test_back_to_back();
    load_base();
    dmem[7] = 32'd3;
    run_and_check("b2b_first", 4, 0);
    load_base();
    run_and_check("b2b_second", 3, 2);
  endtask

  task automatic test_random();
    int lim, h;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NR; i++) begin
        greg[i] = $urandom;
        dreg[i] = ($urandom_range(0, 7) == 0) ? greg[i] ^ (32'h1 << $urandom_range(0, 31)) : greg[i];
      end
      for (int i = 0; i < MD; i++) begin
        gmem[i] = $urandom;
        dmem[i] = ($urandom_range(0, 7) == 0) ? gmem[i] ^ (32'h1 << $urandom_range(0, 31)) : gmem[i];
      end
      lim = int'($urandom_range(0, 20));
      h   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lim + 3)) : 0;
      run_and_check($sformatf("random%0d", it), lim, h);
    end
  endtask

  task automatic test_reset_mid();
    load_base();
    dreg[1] = 32'd5; dreg[2] = 32'd6;
    @(negedge clk); start = 1'b1; cycle_limit = CW'(2);
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (err_count !== EW'(2) || chk_addr === '0) begin
      errors++;
      $display("FAIL mid_check_progress: err=%0d chk_addr=%0d required err=2 addr nonzero", err_count, chk_addr);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({run_en, cycles_run, chk_sel, chk_addr, finish, pass, err_count, first_err_sel, first_err_addr} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: run_en=%b cyc=%0d sel=%b addr=%0d fin=%b err=%0d fea=%0d required all 0",
               run_en, cycles_run, chk_sel, chk_addr, finish, err_count, first_err_addr);
    end
    @(negedge clk); rst = 1'b0;
    run_and_check("after_reset", 6, 0);
  endtask

  initial begin
    test_reset();
    test_match();
    test_single_mismatch();
    test_two_mismatch();
    test_halt();
    test_zero_limit();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
